// File: rtl/sr_lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 sizes, FSM states and
// the captured request record.
package sr_lsu_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsuState_e;

    // Request as captured from the core in IDLE
    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsuReq_t;

endpackage

// File: rtl/sr_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication,
// load extraction/extension and the misalignment/illegal-size check.
module sr_lsu_align
    import sr_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdataRep,
    output logic [31:0] loadData,
    output logic        misalign
);

    logic [31:0] shifted;

    // Bring the addressed byte/half down to bit 0
    assign shifted = rdata >> {addr, 3'b000};

    // Decode size: lanes, replicated store data, extension, alignment fault
    always_comb begin
        be       = 4'b0000;
        wdataRep = wdata;
        loadData = shifted;
        misalign = 1'b0;
        case (funct3)
            LSU_B: begin
                be       = 4'b0001 << addr;
                wdataRep = {4{wdata[7:0]}};
                loadData = {{24{shifted[7]}}, shifted[7:0]};
            end
            LSU_BU: begin
                be       = 4'b0001 << addr;
                wdataRep = {4{wdata[7:0]}};
                loadData = {24'd0, shifted[7:0]};
            end
            LSU_H: begin
                be       = 4'b0011 << addr;
                wdataRep = {2{wdata[15:0]}};
                loadData = {{16{shifted[15]}}, shifted[15:0]};
                misalign = addr[0];
            end
            LSU_HU: begin
                be       = 4'b0011 << addr;
                wdataRep = {2{wdata[15:0]}};
                loadData = {16'd0, shifted[15:0]};
                misalign = addr[0];
            end
            LSU_W: begin
                be       = 4'b1111;
                misalign = (addr != 2'b00);
            end
            default: misalign = 1'b1;   // 011, 110, 111 are not valid sizes
        endcase
    end

endmodule

// File: rtl/sr_lsu.sv
// Load/store unit: captures the core request, runs it over a valid/ready
// bus with a separate read-response channel, stalls the core until done.
module sr_lsu
    import sr_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        fault_misalign,
    output logic        bus_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    lsuState_e        state, stateNext;
    lsuReq_t          cap;
    logic [CNT_W-1:0] cnt;
    logic             fltFlag, errFlag;
    logic [31:0]      loadDataQ;

    logic [2:0]  alnF3;
    logic [1:0]  alnAddr;
    logic [3:0]  alnBe;
    logic [31:0] alnWdata, alnLoad;
    logic        alnMisalign;
    logic        timeoutHit;

    // In IDLE the live request is checked for alignment; afterwards the
    // captured copy keeps the bus fields stable until accepted.
    assign alnF3   = (state == LSU_IDLE) ? req_funct3    : cap.funct3;
    assign alnAddr = (state == LSU_IDLE) ? req_addr[1:0] : cap.addr[1:0];

    sr_lsu_align uAlign (
        .funct3   (alnF3),
        .addr     (alnAddr),
        .wdata    (cap.wdata),
        .rdata    (bus_rdata),
        .be       (alnBe),
        .wdataRep (alnWdata),
        .loadData (alnLoad),
        .misalign (alnMisalign)
    );

    // This REQ/WAIT cycle is the TIMEOUT_CYCLES-th one: abort now
    assign timeoutHit = (TIMEOUT_CYCLES != 0) &&
                        (cnt + CNT_W'(1) == CNT_W'(TIMEOUT_CYCLES));

    assign stall          = req_valid & ~done;
    assign done           = (state == LSU_DONE);
    assign fault_misalign = done & fltFlag;
    assign bus_err        = done & errFlag;
    assign load_data      = loadDataQ;
    assign bus_valid      = (state == LSU_REQ);
    assign bus_addr       = {cap.addr[31:2], 2'b00};
    assign bus_we         = cap.we;
    assign bus_be         = alnBe;
    assign bus_wdata      = alnWdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= LSU_IDLE;
        else     state <= stateNext;
    end

    // Next-state: timeout takes priority over bus handshakes
    always_comb begin
        stateNext = state;
        case (state)
            LSU_IDLE: if (req_valid) stateNext = alnMisalign ? LSU_DONE : LSU_REQ;
            LSU_REQ: begin
                if (timeoutHit)     stateNext = LSU_DONE;
                else if (bus_ready) stateNext = cap.we ? LSU_DONE : LSU_WAIT;
            end
            LSU_WAIT: begin
                if (timeoutHit)      stateNext = LSU_DONE;
                else if (bus_rvalid) stateNext = LSU_DONE;
            end
            LSU_DONE: stateNext = LSU_IDLE;
            default:  stateNext = LSU_IDLE;
        endcase
    end

    // Capture regs, timeout counter, status flags and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            cap       <= '0;
            cnt       <= '0;
            fltFlag   <= 1'b0;
            errFlag   <= 1'b0;
            loadDataQ <= 32'd0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        cap.we     <= req_we;
                        cap.funct3 <= req_funct3;
                        cap.addr   <= req_addr;
                        cap.wdata  <= req_wdata;
                        fltFlag    <= alnMisalign;
                        errFlag    <= 1'b0;
                        cnt        <= '0;
                    end
                end
                LSU_REQ, LSU_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (timeoutHit) begin
                        errFlag   <= 1'b1;
                        loadDataQ <= 32'd0;
                    end else if (state == LSU_WAIT && bus_rvalid) begin
                        loadDataQ <= alnLoad;
                    end
                end
                LSU_DONE: begin
                    fltFlag <= 1'b0;
                    errFlag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_lsu.sv
// Randomized + directed bench for sr_lsu against a transaction-level model.
module tb_sr_lsu;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, fault_misalign, bus_err;
    logic [31:0] load_data;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int nChecks = 0;
    int nPass   = 0;
    logic [31:0] modelLoad = 32'd0;

    sr_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_data(load_data), .done(done),
        .fault_misalign(fault_misalign), .bus_err(bus_err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_we(bus_we), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int sizeOf(input logic [2:0] f3);
        if (f3 == 3'b010) return 4;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 1;
    endfunction

    function automatic bit isBad(input logic [2:0] f3, input logic [31:0] a);
        if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1;
        return (a % sizeOf(f3)) != 0;
    endfunction

    function automatic logic [31:0] expBe(input logic [2:0] f3, input logic [31:0] a);
        int unsigned v;
        v = ((1 << sizeOf(f3)) - 1) << (a % 4);
        return v & 32'hF;
    endfunction

    function automatic logic [31:0] expWd(input logic [2:0] f3, input logic [31:0] wd);
        if (sizeOf(f3) == 1) return (wd & 32'hFF) * 32'h01010101;
        if (sizeOf(f3) == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
        logic [31:0] w, v;
        w = rd >> ((a % 4) * 8);
        case (f3)
            3'b000: begin v = w % 256;   if (v >= 128)   v = v - 256;   end
            3'b100: v = w % 256;
            3'b001: begin v = w % 65536; if (v >= 32768) v = v - 65536; end
            3'b101: v = w % 65536;
            default: v = w;
        endcase
        return v;
    endfunction

    // One access from the IDLE cycle through done; entered and left at posedge+1
    task automatic runAccess(input string nm, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int rdy, input int rv);
        int expStall, nStall, validCnt, accAt, reqWait;
        bit bad, expErr, sawDone, seenValid, stable;
        logic [31:0] fAddr, fWd;
        logic [3:0]  fBe;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = rd;
        bad = isBad(f3, a);
        reqWait = rdy + 1 + (we ? 0 : rv + 1);
        expErr = 0;
        if (bad) expStall = 1;
        else if (reqWait >= TO) begin expStall = 1 + TO; expErr = 1; modelLoad = 32'd0; end
        else begin expStall = 1 + reqWait; if (!we) modelLoad = expLoad(f3, a, rd); end
        nStall = 0; validCnt = 0; accAt = -1; sawDone = 0; seenValid = 0; stable = 1;
        fAddr = '0; fWd = '0; fBe = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (cyc == 0) chk($sformatf("%s.idleDone", nm), {31'd0, done}, 32'd0);
            if (done) begin
                sawDone = 1;
                chk($sformatf("%s.fault", nm), {31'd0, fault_misalign}, {31'd0, bad});
                chk($sformatf("%s.err", nm), {31'd0, bus_err}, {31'd0, expErr});
                chk($sformatf("%s.stallAtDone", nm), {31'd0, stall}, 32'd0);
                chk($sformatf("%s.loadData", nm), load_data, modelLoad);
                break;
            end
            if (stall) nStall++;
            if (bus_valid) begin
                if (!seenValid) begin
                    seenValid = 1;
                    fAddr = bus_addr; fBe = bus_be; fWd = bus_wdata;
                    chk($sformatf("%s.addr", nm), bus_addr, a & 32'hFFFFFFFC);
                    chk($sformatf("%s.be", nm), {28'd0, bus_be}, expBe(f3, a));
                    chk($sformatf("%s.we", nm), {31'd0, bus_we}, {31'd0, we});
                    if (we) chk($sformatf("%s.wdata", nm), bus_wdata, expWd(f3, wd));
                end else if (bus_addr !== fAddr || bus_be !== fBe || bus_wdata !== fWd) begin
                    stable = 0;
                end
                bus_ready = (validCnt >= rdy);
                validCnt++;
            end else begin
                bus_ready = 1'b0;
            end
            if (we) bus_rvalid = 1'($urandom_range(0, 1));   // must be ignored
            else    bus_rvalid = (accAt >= 0) && (cyc == accAt + 1 + rv);
            if (bus_valid && bus_ready) accAt = cyc;
        end
        chk($sformatf("%s.done", nm), {31'd0, sawDone}, 32'd1);
        chk($sformatf("%s.stallCycles", nm), nStall, expStall);
        chk($sformatf("%s.busUsed", nm), {31'd0, seenValid}, {31'd0, !bad});
        if (seenValid) chk($sformatf("%s.stable", nm), {31'd0, stable}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    endtask

    task automatic idleGap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("gap.done", {31'd0, done}, 32'd0);
            chk("gap.valid", {31'd0, bus_valid}, 32'd0);
            chk("gap.loadData", load_data, modelLoad);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [2:0] legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.valid", {31'd0, bus_valid}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.fault", {31'd0, fault_misalign}, 32'd0);
        chk("rst.err", {31'd0, bus_err}, 32'd0);
        chk("rst.loadData", load_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases
        runAccess("LW100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        runAccess("LB103", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 0);
        runAccess("LBU103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 0);
        idleGap(1);
        runAccess("SH202", 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 4, 0);
        runAccess("LWmis", 1'b0, 3'b010, 32'h101, 32'h0, 32'h55555555, 0, 0);
        runAccess("F011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h55555555, 0, 0);
        runAccess("LHU", 1'b0, 3'b101, 32'h302, 32'h0, 32'h9ABC1234, 1, 2);
        runAccess("LH", 1'b0, 3'b001, 32'h302, 32'h0, 32'h9ABC1234, 0, 1);
        runAccess("TOstuck", 1'b0, 3'b010, 32'h400, 32'h0, 32'h12345678, 1000, 0);
        idleGap(2);

        // Random accesses
        for (int n = 0; n < 60; n++) begin
            logic [2:0] f3;
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else f3 = legal[$urandom_range(0, 4)];
            runAccess($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), f3,
                      32'h1000 + $urandom_range(0, 255), $urandom, $urandom,
                      $urandom_range(0, 4), $urandom_range(0, 4));
            idleGap($urandom_range(0, 2));
        end

        // Reset while waiting for read data; the late rvalid must be ignored
        runAccess("LWpre", 1'b0, 3'b010, 32'h500, 32'h0, 32'hCAFEF00D, 0, 0);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h600;
        @(posedge clk); #1;                       // IDLE -> REQ
        @(negedge clk);
        chk("rstw.reqValid", {31'd0, bus_valid}, 32'd1);
        bus_ready = 1'b1;
        @(posedge clk); #1;                       // REQ -> WAIT
        bus_ready = 1'b0; rst = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        modelLoad = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rstw.done", {31'd0, done}, 32'd0);
            chk("rstw.valid", {31'd0, bus_valid}, 32'd0);
            chk("rstw.loadData", load_data, 32'd0);
            @(posedge clk); #1;
        end
        bus_rvalid = 1'b0;
        runAccess("LWpost", 1'b0, 3'b010, 32'h700, 32'h0, 32'h0BADF00D, 0, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
